// File: rtl/motor_speed_pi_ctrl_pkg.sv
// Shared definitions for the motor speed PI controller: datapath widths,
// FSM state encoding and small arithmetic helpers.
package motor_speed_pi_ctrl_pkg;

  localparam int SPEED_W  = 16;  // unsigned speed magnitude
  localparam int SSPEED_W = 17;  // signed speed
  localparam int ERR_W    = 18;  // signed error T - M
  localparam int PROD_W   = 26;  // gain products
  localparam int INTEG_W  = 32;  // integrator
  localparam int SUM_W    = 33;  // p + integ, wide enough never to wrap

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ERR  = 3'd1;
  localparam logic [2:0] ST_MUL  = 3'd2;
  localparam logic [2:0] ST_ACC  = 3'd3;
  localparam logic [2:0] ST_SAT  = 3'd4;

  // Symmetric saturation of v to the range [-lim, +lim] (lim >= 0).
  function automatic logic signed [SUM_W-1:0] sat_clamp(
    input logic signed [SUM_W-1:0] v,
    input logic signed [SUM_W-1:0] lim
  );
    if (v > lim)
      return lim;
    else if (v < -lim)
      return -lim;
    else
      return v;
  endfunction

  // Magnitude plus direction (1 = forward) to a signed speed.
  function automatic logic signed [SSPEED_W-1:0] to_signed_speed(
    input logic [SPEED_W-1:0] mag,
    input logic               fwd
  );
    logic signed [SSPEED_W-1:0] m;
    m = $signed({1'b0, mag});
    return fwd ? m : -m;
  endfunction

endpackage

// File: rtl/motor_speed_pi_ctrl_if.sv
// Measurement strobe bundle from the encoder speed block to the controller.
interface motor_speed_pi_ctrl_if;
  import motor_speed_pi_ctrl_pkg::*;

  logic               meas_valid;
  logic [SPEED_W-1:0] meas_speed;
  logic               meas_dir;

  modport master (output meas_valid, output meas_speed, output meas_dir);
  modport slave  (input  meas_valid, input  meas_speed, input  meas_dir);
endinterface

// File: rtl/motor_speed_pi_ctrl_pwm_period_gen.sv
// PWM stage: 1 us tick, period counter, duty/direction shadow registers that
// load only at a period start, and a zero-duty dead period on direction reversal.
module pwm_period_gen #(
  parameter int CLK_FREQUENCY = 100,
  parameter int PWM_PERIOD    = 2000
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [15:0] duty,
  input  logic        dir_cmd,
  output logic        pwm_o,
  output logic        dir_o
);
  localparam int TW = (CLK_FREQUENCY > 1) ? $clog2(CLK_FREQUENCY) : 1;

  logic [TW-1:0] tick_cnt_reg;
  logic [15:0]   count_reg;
  logic [15:0]   applied_duty_reg;
  logic          rev_pend_reg;
  logic          us_tick;
  logic          period_end;

  assign us_tick    = (tick_cnt_reg == TW'(CLK_FREQUENCY - 1));
  assign period_end = us_tick && (count_reg == 16'(PWM_PERIOD - 1));

  // Divide mclk down to a 1 us tick.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst)
      tick_cnt_reg <= '0;
    else if (us_tick)
      tick_cnt_reg <= '0;
    else
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
  end

  // Microsecond position within the PWM period.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst)
      count_reg <= '0;
    else if (us_tick)
      count_reg <= (count_reg == 16'(PWM_PERIOD - 1)) ? 16'd0 : count_reg + 16'd1;
  end

  // Shadow load at the edge entering count 0; a reversal first burns one
  // full period at zero duty with the old direction still applied.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      applied_duty_reg <= '0;
      dir_o            <= 1'b1;
      rev_pend_reg     <= 1'b0;
    end else if (period_end) begin
      if (!rev_pend_reg && (dir_cmd != dir_o)) begin
        applied_duty_reg <= '0;
        rev_pend_reg     <= 1'b1;
      end else begin
        applied_duty_reg <= duty;
        dir_o            <= dir_cmd;
        rev_pend_reg     <= 1'b0;
      end
    end
  end

  assign pwm_o = (count_reg < applied_duty_reg);

endmodule

// File: rtl/motor_speed_pi_ctrl.sv
// Closed-loop PI speed controller for one DC motor. One control update runs
// per measurement strobe through IDLE -> ERR -> MUL -> ACC -> SAT.
// Build option: define SPEED_PI_INTEGRAL_EN for PI; undefined gives pure P.
module motor_speed_pi_ctrl
  import motor_speed_pi_ctrl_pkg::*;
#(
  parameter int         CLK_FREQUENCY = 100,
  parameter int         PWM_PERIOD    = 2000,
  parameter logic [7:0] KP            = 8'd4,
  parameter logic [7:0] KI            = 8'd1,
  parameter int         OUT_SHIFT     = 4
) (
  input  logic                 mclk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [SPEED_W-1:0]   target_speed,
  input  logic                 target_dir,
  motor_speed_pi_ctrl_if.slave meas,
  output logic                 pwm_o,
  output logic                 dir_o,
  output logic [15:0]          duty_o,
  output logic                 overrun_o
);
  localparam logic signed [SUM_W-1:0] DUTY_LIM = SUM_W'(PWM_PERIOD);

  state_t                      state_reg;
  logic signed [SSPEED_W-1:0]  t_reg, m_reg;
  logic signed [ERR_W-1:0]     e_reg;
  logic signed [PROD_W-1:0]    p_reg;
  logic signed [SUM_W-1:0]     s_reg;
  logic                        dir_cmd_reg;

  logic signed [PROD_W-1:0]    e_ext, kp_ext, p_next;
  logic signed [SUM_W-1:0]     p_ext, s_next, u, u_c, u_abs;
  logic [15:0]                 duty_next;

  assign e_ext  = {{(PROD_W-ERR_W){e_reg[ERR_W-1]}}, e_reg};
  assign kp_ext = {{(PROD_W-8){1'b0}}, KP};
  assign p_next = kp_ext * e_ext;
  assign p_ext  = {{(SUM_W-PROD_W){p_reg[PROD_W-1]}}, p_reg};

  assign u         = s_reg >>> OUT_SHIFT;
  assign u_c       = sat_clamp(u, DUTY_LIM);
  assign u_abs     = u_c[SUM_W-1] ? -u_c : u_c;
  assign duty_next = u_abs[15:0];

`ifdef SPEED_PI_INTEGRAL_EN
  localparam logic signed [SUM_W-1:0] INTEG_LIM = SUM_W'(longint'(PWM_PERIOD) << OUT_SHIFT);

  logic signed [PROD_W-1:0]  ki_ext, i_next, i_inc_reg;
  logic signed [INTEG_W-1:0] integ_reg;
  logic                      clamp_pos_reg, clamp_neg_reg;
  logic signed [SUM_W-1:0]   i_ext, integ_ext, integ_sat, integ_new;
  logic                      hold_integ;
  logic                      unused_bits;

  assign ki_ext     = {{(PROD_W-8){1'b0}}, KI};
  assign i_next     = ki_ext * e_ext;
  assign i_ext      = {{(SUM_W-PROD_W){i_inc_reg[PROD_W-1]}}, i_inc_reg};
  assign integ_ext  = {integ_reg[INTEG_W-1], integ_reg};
  assign integ_sat  = sat_clamp(integ_ext + i_ext, INTEG_LIM);
  // Anti-windup: don't push further into a clamp the output is already at.
  assign hold_integ = (clamp_pos_reg && (e_reg > 0)) || (clamp_neg_reg && (e_reg < 0));
  assign integ_new  = hold_integ ? integ_ext : integ_sat;
  assign s_next     = p_ext + integ_new;
  assign unused_bits = ^{u_abs[SUM_W-1:16], integ_new[SUM_W-1]};

  // Integrator, integral increment and last-cycle clamp flags.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      i_inc_reg     <= '0;
      integ_reg     <= '0;
      clamp_pos_reg <= 1'b0;
      clamp_neg_reg <= 1'b0;
    end else if (!en) begin
      integ_reg     <= '0;
      clamp_pos_reg <= 1'b0;
      clamp_neg_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_MUL: i_inc_reg <= i_next;
        ST_ACC: integ_reg <= integ_new[INTEG_W-1:0];
        ST_SAT: begin
          clamp_pos_reg <= (u > DUTY_LIM);
          clamp_neg_reg <= (u < -DUTY_LIM);
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_bits;

  assign s_next      = p_ext;
  assign unused_bits = ^{u_abs[SUM_W-1:16], KI};
`endif

  // Control FSM: one update per accepted strobe; SAT may accept the next one.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      t_reg       <= '0;
      m_reg       <= '0;
      e_reg       <= '0;
      p_reg       <= '0;
      s_reg       <= '0;
      duty_o      <= '0;
      dir_cmd_reg <= 1'b1;
      overrun_o   <= 1'b0;
    end else if (!en) begin
      state_reg <= ST_IDLE;
      duty_o    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (meas.meas_valid) begin
            t_reg     <= to_signed_speed(target_speed, target_dir);
            m_reg     <= to_signed_speed(meas.meas_speed, meas.meas_dir);
            state_reg <= ST_ERR;
          end
        end
        ST_ERR: begin
          e_reg     <= {t_reg[SSPEED_W-1], t_reg} - {m_reg[SSPEED_W-1], m_reg};
          state_reg <= ST_MUL;
          if (meas.meas_valid) overrun_o <= 1'b1;
        end
        ST_MUL: begin
          p_reg     <= p_next;
          state_reg <= ST_ACC;
          if (meas.meas_valid) overrun_o <= 1'b1;
        end
        ST_ACC: begin
          s_reg     <= s_next;
          state_reg <= ST_SAT;
          if (meas.meas_valid) overrun_o <= 1'b1;
        end
        ST_SAT: begin
          duty_o      <= duty_next;
          dir_cmd_reg <= ~u_c[SUM_W-1];
          if (meas.meas_valid) begin
            t_reg     <= to_signed_speed(target_speed, target_dir);
            m_reg     <= to_signed_speed(meas.meas_speed, meas.meas_dir);
            state_reg <= ST_ERR;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  pwm_period_gen #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .PWM_PERIOD   (PWM_PERIOD)
  ) u_pwm (
    .mclk   (mclk),
    .rst    (rst),
    .duty   (duty_o),
    .dir_cmd(dir_cmd_reg),
    .pwm_o  (pwm_o),
    .dir_o  (dir_o)
  );

endmodule

// File: tb/tb_motor_speed_pi_ctrl.sv
// Scoreboard bench for motor_speed_pi_ctrl with a plain-arithmetic PI model.
`timescale 1ns/1ps
module tb_motor_speed_pi_ctrl;
  localparam int CLK_FREQUENCY = 10;
  localparam int PWM_PERIOD    = 100;
  localparam int KP_I          = 4;
  localparam int KI_I          = 1;
  localparam int OUT_SHIFT     = 4;
  localparam int PER_CYC       = CLK_FREQUENCY * PWM_PERIOD;
`ifdef SPEED_PI_INTEGRAL_EN
  localparam int EXP_15 = 15;
  localparam int EXP_WINDUP = 62;
  localparam int SPD_50 = 160;
`else
  localparam int EXP_15 = 12;
  localparam int EXP_WINDUP = 0;
  localparam int SPD_50 = 200;
`endif

  logic        mclk = 1'b0;
  logic        rst  = 1'b1;
  logic        en   = 1'b0;
  logic [15:0] target_speed = '0;
  logic        target_dir   = 1'b1;
  logic        pwm_o, dir_o, overrun_o;
  logic [15:0] duty_o;

  motor_speed_pi_ctrl_if mif();

  motor_speed_pi_ctrl #(
    .CLK_FREQUENCY(CLK_FREQUENCY), .PWM_PERIOD(PWM_PERIOD),
    .KP(8'(KP_I)), .KI(8'(KI_I)), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .mclk(mclk), .rst(rst), .en(en),
    .target_speed(target_speed), .target_dir(target_dir),
    .meas(mif),
    .pwm_o(pwm_o), .dir_o(dir_o), .duty_o(duty_o), .overrun_o(overrun_o)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct { int due; int kind; int val; } rec_t;  // kind 0 duty, 1 overrun
  rec_t sb_q[$];

  // Reference model state
  longint integ_m;
  int     clamp_m;
  int     duty_m;
  bit     dir_m;
  bit     ovr_m;
  int     last_acc;
  int     r_cyc;
  longint snap_integ;
  int     snap_clamp, snap_duty;
  bit     snap_dir;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    integ_m = 0; clamp_m = 0; duty_m = 0; dir_m = 1'b1; ovr_m = 1'b0;
    last_acc = -100;
    sb_q.delete();
  endtask

  // One control update computed straight from the controller rules.
  task automatic model_update(input bit td, input int ts, input bit md, input int ms);
    longint t, m, e, p, s, u, lim, div;
    t = td ? ts : -ts;
    m = md ? ms : -ms;
    e = t - m;
    p = KP_I * e;
    div = 1 << OUT_SHIFT;
    lim = longint'(PWM_PERIOD) * div;
`ifdef SPEED_PI_INTEGRAL_EN
    if (!((clamp_m > 0 && e > 0) || (clamp_m < 0 && e < 0))) begin
      integ_m = integ_m + KI_I * e;
      if (integ_m > lim) integ_m = lim;
      if (integ_m < -lim) integ_m = -lim;
    end
    s = p + integ_m;
`else
    s = p;
`endif
    u = (s >= 0) ? s / div : -((-s + div - 1) / div);
    clamp_m = (u > PWM_PERIOD) ? 1 : (u < -PWM_PERIOD) ? -1 : 0;
    if (clamp_m > 0) u = PWM_PERIOD;
    if (clamp_m < 0) u = -PWM_PERIOD;
    duty_m = int'((u < 0) ? -u : u);
    dir_m  = (u >= 0);
  endtask

  // Issue one meas_valid strobe at the current negedge; expectation goes to the scoreboard.
  task automatic strobe(input bit td, input int ts, input bit md, input int ms);
    int k, d;
    k = cyc;
    target_dir = td; target_speed = 16'(ts);
    mif.meas_dir = md; mif.meas_speed = 16'(ms); mif.meas_valid = 1'b1;
    d = k + 1 - last_acc;
    if (en) begin
      if (d >= 1 && d <= 3) begin
        ovr_m = 1'b1;
        sb_q.push_back('{due: k + 1, kind: 1, val: 1});
      end else begin
        snap_integ = integ_m; snap_clamp = clamp_m; snap_duty = duty_m; snap_dir = dir_m;
        model_update(td, ts, md, ms);
        last_acc = k + 1;
        sb_q.push_back('{due: k + 5, kind: 0, val: duty_m});
      end
    end else begin
      sb_q.push_back('{due: k + 1, kind: 1, val: int'(ovr_m)});
    end
    $display("[TB] strobe cyc=%0d T=%0s%0d M=%0s%0d en=%0b", k, td ? "+" : "-", ts, md ? "+" : "-", ms, en);
    @(negedge mclk);
    mif.meas_valid = 1'b0;
  endtask

  // Drop en at the current negedge, discarding any update in flight.
  task automatic drop_en();
    int k;
    k = cyc;
    en = 1'b0;
    if (k + 1 - last_acc >= 1 && k + 1 - last_acc <= 4) begin
      dir_m = snap_dir;
      for (int i = sb_q.size() - 1; i >= 0; i--)
        if (sb_q[i].kind == 0 && sb_q[i].due >= k + 1) sb_q.delete(i);
    end
    integ_m = 0; clamp_m = 0; duty_m = 0; last_acc = -100;
    sb_q.push_back('{due: k + 1, kind: 0, val: 0});
  endtask

  // Monitor: compare every scoreboard entry that falls due on this cycle.
  always @(negedge mclk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        if (sb_q[i].kind == 0) begin
          check("duty_o", duty_o, sb_q[i].val);
          $display("[TB] check duty_o cyc=%0d got=%0d exp=%0d", cyc, duty_o, sb_q[i].val);
        end else begin
          check("overrun_o", overrun_o, sb_q[i].val);
          $display("[TB] check overrun_o cyc=%0d got=%0b exp=%0d", cyc, overrun_o, sb_q[i].val);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic wait_start();
    int n;
    n = 0;
    while (((cyc - r_cyc) % PER_CYC) != 0 && n < PER_CYC + 2) begin
      @(negedge mclk);
      n++;
    end
  endtask

  // Check one whole PWM period, beginning at the next period start.
  task automatic measure(input string name, input int exp_duty, input bit exp_dir);
    int bad, highs;
    bad = 0; highs = 0;
    wait_start();
    check({name, "_dir_o"}, dir_o, exp_dir);
    for (int i = 0; i < PER_CYC; i++) begin
      if (pwm_o) highs++;
      if (pwm_o !== ((i / CLK_FREQUENCY) < exp_duty)) bad++;
      @(negedge mclk);
    end
    check({name, "_pwm_bad_cycles"}, bad, 0);
    $display("[TB] period %s high_cycles=%0d exp_duty=%0d dir_o=%0b exp_dir=%0b", name, highs, exp_duty, dir_o, exp_dir);
  endtask

  // Let a pending update (and a possible dead period) pass, then check a period.
  task automatic settle(input string name);
    repeat (5) @(negedge mclk);
    wait_start();
    @(negedge mclk);
    measure(name, duty_m, dir_m);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, off;
    mif.meas_valid = 1'b0; mif.meas_speed = '0; mif.meas_dir = 1'b1;
    model_reset();
    r_cyc = 0;
    repeat (3) @(negedge mclk);
    check("reset_no_x", $isunknown({pwm_o, dir_o, duty_o, overrun_o}), 0);
    check("reset_duty_o", duty_o, 0);
    check("reset_pwm_o", pwm_o, 0);
    check("reset_dir_o", dir_o, 1);
    check("reset_overrun_o", overrun_o, 0);
    rst = 1'b0; r_cyc = cyc; en = 1'b1;
    repeat (2) @(negedge mclk);

    // Basic forward update
    strobe(1, 100, 1, 50);
    repeat (5) @(negedge mclk);
    check("first_duty", duty_o, EXP_15);
    measure("fwd", EXP_15, 1);

    // Reversal: dead period, then new direction and duty
    strobe(1, 0, 1, 50);
    repeat (5) @(negedge mclk);
    check("rev_duty", duty_o, 13);
    measure("rev_dead", 0, 1);
    measure("rev_new", 13, 0);

    // Random updates, both directions, including back-to-back acceptance in SAT
    for (int n = 0; n < 20; n++) begin
      strobe(1'($urandom_range(0, 1)), $urandom_range(0, 600), 1'($urandom_range(0, 1)), $urandom_range(0, 600));
      g = $urandom_range(4, 9);
      repeat (g - 1) @(negedge mclk);
    end
    settle("rand");

    // Saturation and anti-windup, from a cleared integrator
    drop_en(); @(negedge mclk); en = 1'b1; @(negedge mclk);
    for (int n = 0; n < 5; n++) begin
      strobe(1, 1000, 1, 0);
      repeat (6) @(negedge mclk);
    end
    check("sat_duty", duty_o, PWM_PERIOD);
    settle("sat");
    strobe(1, 100, 1, 100);
    repeat (5) @(negedge mclk);
    check("windup_hold", duty_o, EXP_WINDUP);
    repeat (4) @(negedge mclk);

    // en low during MUL discards the update; strobe with en low is ignored
    strobe(1, 100, 1, 50);
    @(negedge mclk);
    drop_en();
    sb_q.push_back('{due: cyc + 3, kind: 0, val: 0});
    @(negedge mclk);
    strobe(1, 500, 1, 0);
    repeat (4) @(negedge mclk);
    check("en_low_overrun", overrun_o, 0);
    en = 1'b1;
    @(negedge mclk);
    strobe(1, 100, 1, 50);
    repeat (5) @(negedge mclk);
    check("en_cleared_integ", duty_o, EXP_15);
    repeat (4) @(negedge mclk);

    // Overrun: strobe two cycles after an accepted one, then a random offset
    strobe(1, 200, 1, 0);
    @(negedge mclk);
    strobe(0, 300, 1, 0);
    repeat (8) @(negedge mclk);
    strobe(1, 250, 0, 10);
    off = $urandom_range(1, 3);
    repeat (off - 1) @(negedge mclk);
    strobe(0, 400, 0, 0);
    repeat (10) @(negedge mclk);
    check("overrun_sticky", overrun_o, 1);

    // Reset mid-period with duty 50
    drop_en(); @(negedge mclk); en = 1'b1; @(negedge mclk);
    strobe(1, SPD_50, 1, 0);
    repeat (5) @(negedge mclk);
    check("duty50", duty_o, 50);
    settle("d50");
    wait_start();
    repeat (20) @(negedge mclk);
    check("pre_rst_pwm_high", pwm_o, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm_o", pwm_o, 0);
    check("async_rst_duty_o", duty_o, 0);
    check("async_rst_overrun_o", overrun_o, 0);
    check("async_rst_dir_o", dir_o, 1);
    model_reset();
    @(negedge mclk);
    rst = 1'b0; r_cyc = cyc;
    measure("post_rst", 0, 1);
    strobe(1, SPD_50, 1, 0);
    repeat (5) @(negedge mclk);
    measure("post_rst_d50", 50, 1);

    repeat (10) @(negedge mclk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/motor_speed_pi_ctrl.md
# motor_speed_pi_ctrl

Closed-loop speed controller for one quadrature-encoded DC motor. It takes the per-window speed and direction from the encoder measurement block, runs a fixed-point PI loop against a commanded signed speed, and drives the motor through a PWM output plus a direction line. It sits between the encoder speed datapath and the H-bridge pins, and it sequences one control update per measurement window.

## Interface
- CLK_FREQUENCY, 100: mclk frequency in MHz; 1 µs tick = CLK_FREQUENCY mclk cycles.
- PWM_PERIOD, 2000: PWM period in µs (2..32767); duty range 0..PWM_PERIOD.
- KP, 8'd4: unsigned proportional gain.
- KI, 8'd1: unsigned integral gain.
- OUT_SHIFT, 4: arithmetic right shift applied to the PI sum.
- mclk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  loop enable; low forces duty 0 and clears the integrator.
- target_speed  in  16  commanded magnitude, in counts per window.
- target_dir  in  1  commanded direction, 1 = forward.
- meas_valid  in  1  one-cycle strobe; speed and direction are valid.
- meas_speed  in  16  measured magnitude.
- meas_dir  in  1  measured direction, 1 = forward.
- pwm_o  out  1  PWM drive.
- dir_o  out  1  applied direction.
- duty_o  out  16  latest computed duty in µs.
- overrun_o  out  1  sticky flag: meas_valid arrived while the FSM was busy.

## Operation
- Signed conversion, 17-bit: T = target_dir ? +target_speed : −target_speed. M is formed the same way from the measurement.
- Error e = T − M, held as 18-bit signed.
- FSM states:
  - IDLE: on meas_valid with en=1, capture T and M, go to ERR.
  - ERR: register e.
  - MUL: register p = KP·e and i_inc = KI·e, 26-bit signed each.
  - ACC: update the integrator (32-bit signed) and register s = p + integ.
  - SAT: compute u = s >>> OUT_SHIFT, clamp to ±PWM_PERIOD, register duty_o = |u| and dir_cmd = (u ≥ 0). Return to IDLE.
- Integrator update:
  - Skip the add when the previous u was clamped and e has the same sign as that clamp (anti-windup).
  - Otherwise saturate the integrator to ±(PWM_PERIOD << OUT_SHIFT).
- en=0:
  - The FSM returns to IDLE on the next edge.
  - The integrator clears to 0 and duty_o = 0.
  - dir_o holds its value.
  - meas_valid is ignored and overrun_o is not set.
- meas_valid outside IDLE is dropped and sets overrun_o. overrun_o clears only on rst.
- PWM generation:
  - The µs counter runs 0..PWM_PERIOD−1.
  - Applied duty and direction load only at count 0.
  - pwm_o = (count < applied_duty).
- Direction reversal: if dir_cmd ≠ dir_o at a period start, that whole period runs with duty 0 and dir_o unchanged. dir_o and the new duty load at the following period start.

## Timing
- Reset values: pwm_o=0, dir_o=1, duty_o=0, overrun_o=0, integrator=0, FSM=IDLE, PWM and µs counters=0.
- Latency from meas_valid sampled at edge N: duty_o updates at edge N+4. The FSM accepts a new meas_valid from edge N+4 onward.
- pwm_o reflects a new duty at the first period start after edge N+4. The worst case is PWM_PERIOD µs, plus one extra period on a direction reversal.
- duty = 0 gives pwm_o constantly 0. duty = PWM_PERIOD gives pwm_o constantly 1.
- Reset mid-operation: all state returns to reset values immediately, and any in-flight update is discarded.
- en falling during ERR/MUL/ACC/SAT: the pending result is discarded.

## Configuration
- SPEED_PI_INTEGRAL_EN:
  - Defined: PI behaviour as above.
  - Undefined: the integrator register, KI multiply and anti-windup are not built, and s = p (pure P control). Latency is unchanged: ACC still takes one cycle.

## Structure
- A shared package holds:
  - FSM state encoding (IDLE, ERR, MUL, ACC, SAT).
  - The width constants: speed 16, signed speed 17, error 18, product 26, integrator 32.
  - A saturating-clamp function.
- One sub-module, pwm_period_gen, provides the µs tick, period counter, duty/direction shadow load with reversal dead period, and pwm_o. The PI FSM stays in the top level.

## Test plan
All scenarios use CLK_FREQUENCY=10, PWM_PERIOD=100, KP=4, KI=1, OUT_SHIFT=4, and check for no X after reset.
- Target fwd 100, meas fwd 50, one strobe -> duty_o=15 (12 without SPEED_PI_INTEGRAL_EN) at edge N+4; pwm_o high for 15 µs of each period from the next period start.
- Target fwd 0, meas fwd 50 after the prior forward state -> u negative, dir_cmd=0; the next period has pwm_o=0 and dir_o=1, the following period has dir_o=0 with the new duty.
- Target fwd 1000, meas 0, repeated strobes -> duty_o clamps at 100, the integrator stops growing, and pwm_o stays high for the full period.
- Second meas_valid 2 cycles after the first -> it is ignored, overrun_o=1 and stays set until rst.
- en low during MUL -> duty_o=0 and integrator=0 on the next edge; a strobe with en=0 leaves overrun_o=0.
- rst asserted mid-PWM period with duty 50 -> pwm_o=0 and duty_o=0 asynchronously; after release the counter restarts from 0.
